// File: rtl/vc32_cpu.sv
// rtl/vc32_cpu.sv - minimal 16-bit load/store CPU on a multiplexed byte-wide memory bus
//
// Ports:
//   clk      system clock, all state on posedge
//   rst_n    asynchronous active-low reset
//   ena      tile enable (unused)
//   ui_in    read data byte from external memory
//   uo_out   address byte (latch cycles) / write data (write cycles) / 0
//   uio_in   [7] interrupt request, level, active-high
//   uio_out  [0] ind (byte select) [1] write [2] latch_hi [3] latch_lo
//   uio_oe   constant 8'h0F
module vc32_cpu #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] IRQ_VEC  = 16'h0004
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [3:0] {
        S_FH, S_FL, S_FR0, S_FR1, S_EX,
        S_MH, S_ML, S_MR0, S_MR1, S_MW0, S_MW1, S_HALT
    } state_t;

    state_t      r_state, w_state_nx;
    logic [15:0] r_pc, r_ir, r_epc, r_maddr;
    logic [7:0]  r_lo;
    logic        r_ie;
    logic [15:0] r_regs [0:7];

    logic [3:0]  w_op;
    logic [2:0]  w_rd, w_rs;
    logic [15:0] w_rdv, w_rsv, w_sext9, w_sext6, w_pc2, w_br, w_maddr;
    logic [15:0] w_pc_nx, w_wb_val;
    logic        w_ie_nx, w_wb_en, w_halt, w_take;
    logic [7:0]  w_uo, w_uio;
    logic        w_unused;

    assign w_unused = &{1'b0, ena, uio_in[6:0]};

    assign w_op    = r_ir[15:12];
    assign w_rd    = r_ir[11:9];
    assign w_rs    = r_ir[8:6];
    assign w_rdv   = (w_rd == 3'd0) ? 16'h0000 : r_regs[w_rd];
    assign w_rsv   = (w_rs == 3'd0) ? 16'h0000 : r_regs[w_rs];
    assign w_sext9 = {{7{r_ir[8]}}, r_ir[8:0]};
    assign w_sext6 = {{10{r_ir[5]}}, r_ir[5:0]};
    assign w_pc2   = r_pc + 16'd2;
    assign w_br    = w_pc2 + {w_sext9[14:0], 1'b0};
    assign w_maddr = (w_rsv + w_sext6) & 16'hFFFE;

    // Execute: register write-back, next pc and next IE for the current state.
    always_comb begin
        w_wb_en  = 1'b0;
        w_wb_val = 16'h0000;
        w_pc_nx  = r_pc;
        w_ie_nx  = r_ie;
        w_halt   = 1'b0;
        if (r_state == S_MR1) begin
            w_wb_en  = 1'b1;
            w_wb_val = {ui_in, r_lo};
        end else if (r_state == S_EX) begin
            w_pc_nx = w_pc2;
            case (w_op)
                4'h0: begin w_wb_en = 1'b1; w_wb_val = w_rdv + w_rsv; end
                4'h1: begin w_wb_en = 1'b1; w_wb_val = w_rdv - w_rsv; end
                4'h2: begin w_wb_en = 1'b1; w_wb_val = w_rdv & w_rsv; end
                4'h3: begin w_wb_en = 1'b1; w_wb_val = w_rdv | w_rsv; end
                4'h4: begin w_wb_en = 1'b1; w_wb_val = w_rdv ^ w_rsv; end
                4'h5: begin w_wb_en = 1'b1; w_wb_val = {1'b0, w_rdv[15:1]}; end
                4'h6: begin w_wb_en = 1'b1; w_wb_val = w_rdv + w_sext9; end
                4'h7: begin w_wb_en = 1'b1; w_wb_val = {r_ir[8:0], 7'b0}; end
                4'hA: if (w_rdv == 16'h0000) w_pc_nx = w_br;
                4'hB: if (w_rdv != 16'h0000) w_pc_nx = w_br;
                4'hC: begin w_wb_en = 1'b1; w_wb_val = w_pc2; w_pc_nx = w_br; end
                4'hD: begin w_wb_en = 1'b1; w_wb_val = w_pc2; w_pc_nx = w_rsv & 16'hFFFE; end
                4'hE: begin
                    case (r_ir[5:0])
                        6'd0: w_ie_nx = 1'b1;
                        6'd1: w_ie_nx = 1'b0;
                        6'd2: begin w_pc_nx = r_epc; w_ie_nx = 1'b1; end
                        6'd3: w_halt = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_FH:   w_state_nx = S_FL;
            S_FL:   w_state_nx = S_FR0;
            S_FR0:  w_state_nx = S_FR1;
            S_FR1:  w_state_nx = S_EX;
            S_EX: begin
                if (w_op == 4'h8 || w_op == 4'h9) w_state_nx = S_MH;
                else if (w_halt)                  w_state_nx = S_HALT;
                else                              w_state_nx = S_FH;
            end
            S_MH:   w_state_nx = S_ML;
            S_ML:   w_state_nx = (w_op == 4'h8) ? S_MR0 : S_MW0;
            S_MR0:  w_state_nx = S_MR1;
            S_MR1:  w_state_nx = S_FH;
            S_MW0:  w_state_nx = S_MW1;
            S_MW1:  w_state_nx = S_FH;
            S_HALT: if (r_ie && uio_in[7]) w_state_nx = S_FH;
            default: w_state_nx = S_FH;
        endcase
    end

    // IE is taken after the current instruction's own effect, so EI lets a
    // pending request in on the very next fetch and DI blocks it.
    assign w_take = (w_state_nx == S_FH) && w_ie_nx && uio_in[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FH;
            r_pc    <= RESET_PC;
            r_ir    <= 16'h0000;
            r_epc   <= 16'h0000;
            r_maddr <= 16'h0000;
            r_lo    <= 8'h00;
            r_ie    <= 1'b0;
            for (int i = 0; i < 8; i++) r_regs[i] <= 16'h0000;
        end else begin
            r_state <= w_state_nx;
            if (w_take) begin
                r_pc  <= IRQ_VEC;
                r_epc <= w_pc_nx;
                r_ie  <= 1'b0;
            end else begin
                r_pc  <= w_pc_nx;
                r_ie  <= w_ie_nx;
            end
            case (r_state)
                S_FR0:   r_ir[7:0]  <= ui_in;
                S_FR1:   r_ir[15:8] <= ui_in;
                S_EX:    r_maddr    <= w_maddr;
                S_MR0:   r_lo       <= ui_in;
                default: ;
            endcase
            if (w_wb_en && w_rd != 3'd0) r_regs[w_rd] <= w_wb_val;
        end
    end

    always_comb begin
        w_uo  = 8'h00;
        w_uio = 8'h00;
        case (r_state)
            S_FH:  begin w_uo = r_pc[15:8];    w_uio = 8'h04; end
            S_FL:  begin w_uo = r_pc[7:0];     w_uio = 8'h08; end
            S_FR1: w_uio = 8'h01;
            S_MH:  begin w_uo = r_maddr[15:8]; w_uio = 8'h04; end
            S_ML:  begin w_uo = r_maddr[7:0];  w_uio = 8'h08; end
            S_MR1: w_uio = 8'h01;
            S_MW0: begin w_uo = w_rdv[7:0];    w_uio = 8'h02; end
            S_MW1: begin w_uo = w_rdv[15:8];   w_uio = 8'h03; end
            default: ;
        endcase
    end

    // Gating with rst_n drops every strobe the moment reset asserts.
    assign uo_out  = rst_n ? w_uo  : 8'h00;
    assign uio_out = rst_n ? w_uio : 8'h00;
    assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_vc32_cpu.sv
// tb/tb_vc32_cpu.sv - self-checking bench for vc32_cpu
module tb_vc32_cpu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       irq = 1'b0;
    logic [7:0] ui_in, uo_out, uio_out, uio_oe, uio_in;

    always #5 clk = ~clk;
    assign uio_in = {irq, 7'b0};

    vc32_cpu dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    // External memory with address latches.
    logic [7:0]  mem [0:65535];
    logic [7:0]  lat_hi = 8'h00, lat_lo = 8'h00;
    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = 16'h0000;
    logic [7:0]  ld_data = 8'h00;

    always @(negedge clk) begin
        if (uio_out[2]) lat_hi <= uo_out;
        if (uio_out[3]) lat_lo <= uo_out;
    end
    assign ui_in = mem[{lat_hi, lat_lo[7:1], uio_out[0]}];
    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (uio_out[1]) mem[{lat_hi, lat_lo[7:1], uio_out[0]}] <= uo_out;
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [15:0] tr [0:1023];
    logic [7:0]  wlo = 8'h00;

    typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
    wr_t sb[$];

    typedef struct { logic [15:0] instr; logic [15:0] a; logic [15:0] b; logic [15:0] exp; } vec_t;
    vec_t vecs [12];

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Bus monitor: cycle trace plus write scoreboard.
    always @(negedge clk) begin
        if (!rst_n) cyc <= 0;
        else begin
            cyc <= cyc + 1;
            if (cyc < 1000) tr[cyc + 1] <= {uo_out, uio_out};
            if (uio_out[1] && !uio_out[0]) wlo <= uo_out;
            if (uio_out[1] && uio_out[0]) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got data=%h expected no write", {uo_out, wlo});
                end else begin
                    chk("write_addr", {lat_hi, lat_lo[7:1], 1'b0}, sb[0].addr);
                    chk("write_data", {uo_out, wlo}, sb[0].data);
                    sb.delete(0);
                end
            end
        end
    end

    task automatic put(input logic [15:0] a, input logic [7:0] d);
        ld_addr = a; ld_data = d; ld_en = 1'b1;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic putw(input logic [15:0] a, input logic [15:0] w);
        put(a, w[7:0]);
        put(a + 16'd1, w[15:8]);
    endtask

    task automatic start_reset();
        rst_n = 1'b0;
        irq = 1'b0;
        for (int i = 0; i < 40; i++) put(16'(i), 8'h00);
        put(16'hFFFE, 8'h00);
        put(16'hFFFF, 8'h00);
    endtask

    task automatic go();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic chk_tr(input string nm, input int c, input logic [15:0] e);
        wait_cyc(c);
        chk(nm, tr[c], e);
    endtask

    task automatic wait_wr(input string nm, input int n);
        for (int k = 0; k < n && sb.size() != 0; k++) @(negedge clk);
        #1;
        chk(nm, 16'(sb.size()), 16'd0);
        sb.delete();
    endtask

    logic [15:0] exp_a [1:21];

    initial begin
        vecs[0]  = '{16'h0280, 16'h1234, 16'h0F0F, 16'h2143}; // ADD r1,r2
        vecs[1]  = '{16'h1280, 16'h0005, 16'h0007, 16'hFFFE}; // SUB wraps
        vecs[2]  = '{16'h2280, 16'hF0F0, 16'h3C3C, 16'h3030}; // AND
        vecs[3]  = '{16'h3280, 16'hF0F0, 16'h3C3C, 16'hFCFC}; // OR
        vecs[4]  = '{16'h4280, 16'hF0F0, 16'h3C3C, 16'hCCCC}; // XOR
        vecs[5]  = '{16'h5200, 16'h8001, 16'h0000, 16'h4000}; // SRL logical
        vecs[6]  = '{16'h63FF, 16'h0000, 16'h0000, 16'hFFFF}; // ADDI -1
        vecs[7]  = '{16'h62FF, 16'hFF80, 16'h0000, 16'h007F}; // ADDI +255 wraps
        vecs[8]  = '{16'h73FF, 16'h1234, 16'h0000, 16'hFF80}; // LUI 0x1FF
        vecs[9]  = '{16'h0080, 16'h5555, 16'h1111, 16'h5555}; // ADD r0 discarded
        vecs[10] = '{16'hC200, 16'h1234, 16'h0000, 16'h000A}; // JAL r1,0
        vecs[11] = '{16'h0240, 16'h8000, 16'h0000, 16'h0000}; // ADD r1,r1 wraps

        exp_a = '{16'h0004, 16'h0008, 16'h0000, 16'h0001, 16'h0000,
                  16'h0004, 16'h0208, 16'h0000, 16'h0001, 16'h0000,
                  16'h0004, 16'h0408, 16'h0000, 16'h0001, 16'h0000,
                  16'hFF04, 16'hFE08, 16'h0302, 16'h0003, 16'h0004, 16'h0608};

        // Reset state and full bus trace of ADDI, ADDI, SW to the debug word.
        start_reset();
        chk("reset_uo_out", {8'h00, uo_out}, 16'h0000);
        chk("reset_uio_out", {8'h00, uio_out}, 16'h0000);
        chk("uio_oe", {8'h00, uio_oe}, 16'h000F);
        putw(0, 16'h6205); putw(2, 16'h63FE); putw(4, 16'h923E); putw(6, 16'hE003);
        sb.push_back('{16'hFFFE, 16'h0003});
        go();
        for (int c = 1; c <= 21; c++) chk_tr($sformatf("trace_sw_c%0d", c), c, exp_a[c]);
        wait_wr("sw_done", 50);

        // Reset asserted during W0: strobes drop and no byte is written.
        start_reset();
        putw(0, 16'h6205); putw(2, 16'h63FE); putw(4, 16'h923E); putw(6, 16'hE003);
        put(16'hFFFE, 8'hAA); put(16'hFFFF, 8'hBB);
        go();
        chk_tr("midrst_w0", 18, 16'h0302);
        rst_n = 1'b0;
        #1;
        chk("midrst_uo_out", {8'h00, uo_out}, 16'h0000);
        chk("midrst_uio_out", {8'h00, uio_out}, 16'h0000);
        repeat (3) @(negedge clk);
        chk("midrst_mem_lo", {8'h00, mem[16'hFFFE]}, 16'h00AA);
        chk("midrst_mem_hi", {8'h00, mem[16'hFFFF]}, 16'h00BB);

        // LW r2,0(r0) reads the ADDI opcode word back.
        start_reset();
        putw(0, 16'h6205); putw(2, 16'h8400); putw(4, 16'h943E); putw(6, 16'hE003);
        sb.push_back('{16'hFFFE, 16'h6205});
        go();
        chk_tr("lw_mh", 11, 16'h0004);
        chk_tr("lw_ml", 12, 16'h0008);
        chk_tr("lw_mr0", 13, 16'h0000);
        chk_tr("lw_mr1", 14, 16'h0001);
        chk_tr("lw_next_h", 15, 16'h0004);
        chk_tr("lw_next_l", 16, 16'h0408);
        wait_wr("lw_done", 60);

        // BNEZ taken loops on itself; not taken falls through; BEQZ taken.
        start_reset();
        putw(0, 16'h6203); putw(2, 16'hB3FF); putw(4, 16'hE003);
        go();
        chk_tr("bnez_taken", 12, 16'h0208);
        start_reset();
        putw(0, 16'h6200); putw(2, 16'hB3FF); putw(4, 16'hE003);
        go();
        chk_tr("bnez_fall", 12, 16'h0408);
        start_reset();
        putw(0, 16'h6200); putw(2, 16'hA201); putw(4, 16'hE003); putw(6, 16'hE003);
        go();
        chk_tr("beqz_taken", 12, 16'h0608);

        // JAL r7,+4 at 0x0010, store r7, JALR r0,r7.
        start_reset();
        putw(0, 16'hC007); putw(16'h10, 16'hCE04); putw(16'h12, 16'hE003);
        putw(16'h1A, 16'h9E3E); putw(16'h1C, 16'hD1C0);
        sb.push_back('{16'hFFFE, 16'h0012});
        go();
        chk_tr("jal_first", 7, 16'h1008);
        chk_tr("jal_target", 12, 16'h1A08);
        chk_tr("jalr_fetch", 21, 16'h1C08);
        chk_tr("jalr_target", 26, 16'h1208);
        wait_wr("jal_done", 60);

        // Interrupt entry right after EI, RETI return, re-entry, DI blocks in HALT.
        start_reset();
        putw(0, 16'hE000); putw(2, 16'hC00E); putw(4, 16'h6407); putw(6, 16'hE002);
        putw(16'h20, 16'h943E); putw(16'h22, 16'hE001); putw(16'h24, 16'hE003);
        sb.push_back('{16'hFFFE, 16'h000E});
        irq = 1'b1;
        go();
        chk_tr("irq_entry", 7, 16'h0408);
        wait_cyc(8); irq = 1'b0;
        chk_tr("irq_reti_fetch", 12, 16'h0608);
        chk_tr("irq_return", 17, 16'h0208);
        wait_cyc(18); irq = 1'b1;
        chk_tr("irq_reentry", 22, 16'h0408);
        wait_cyc(23); irq = 1'b0;
        chk_tr("irq_return2", 32, 16'h2008);
        chk_tr("halt_fetch", 46, 16'h2408);
        wait_cyc(55); irq = 1'b1;
        wait_cyc(70);
        for (int c = 60; c <= 70; c++) chk($sformatf("halt_quiet_c%0d", c), tr[c], 16'h0000);
        chk("irq_writes", 16'(sb.size()), 16'd0);
        sb.delete();

        // Table-driven ALU vectors: set r1/r2, run instruction, store r1.
        for (int i = 0; i < 12; i++) begin
            start_reset();
            putw(0, {4'h7, 3'd1, vecs[i].a[15:7]});
            putw(2, {4'h6, 3'd1, 2'b00, vecs[i].a[6:0]});
            putw(4, {4'h7, 3'd2, vecs[i].b[15:7]});
            putw(6, {4'h6, 3'd2, 2'b00, vecs[i].b[6:0]});
            putw(8, vecs[i].instr);
            putw(10, 16'h923E);
            putw(12, 16'hE003);
            sb.push_back('{16'hFFFE, vecs[i].exp});
            go();
            wait_wr($sformatf("vec%0d_done", i), 150);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
